// File: rtl/rtype_issue_unit_if.sv
// Instruction handshake, ALU operand/result bus and writeback/illegal status.
// master = issue unit side, slave = instruction supplier / ALU side.
interface rtype_issue_unit_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] alu_rs;
   logic [31:0] alu_rt;
   logic [4:0]  alu_shamt;
   logic [5:0]  alu_funct;
   logic [31:0] alu_rd;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        illegal;

   modport master (
      input  instr_valid, instr, alu_rd,
      output instr_ready, alu_rs, alu_rt, alu_shamt, alu_funct,
             wb_valid, wb_addr, wb_data, illegal
   );

   modport slave (
      output instr_valid, instr, alu_rd,
      input  instr_ready, alu_rs, alu_rt, alu_shamt, alu_funct,
             wb_valid, wb_addr, wb_data, illegal
   );
endinterface

// File: rtl/rtype_issue_unit.sv
// R-type issue sequencer: accepts add/sub/srl, drives the ALU, writes back after ALU_LAT cycles.
// One instruction per ALU_LAT+2 cycles; instr_ready is high only in IDLE, illegal words are dropped.
module rtype_issue_unit #(
   parameter int ALU_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rtype_issue_unit_if.master   bus,
   input  logic                 init_we,
   input  logic [4:0]           init_addr,
   input  logic [31:0]          init_data,
   input  logic [4:0]           dbg_addr,
   output logic [31:0]          dbg_data
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   localparam logic [3:0] LAT = 4'(ALU_LAT);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] alu_rs_q, alu_rs_d;
   logic [31:0] alu_rt_q, alu_rt_d;
   logic [4:0]  alu_shamt_q, alu_shamt_d;
   logic [5:0]  alu_funct_q, alu_funct_d;
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_addr_q, wb_addr_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        illegal_q, illegal_d;
   logic [31:0] regs_q [32];

   logic        reg_we;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;

   logic [5:0]  dec_opcode;
   logic [4:0]  dec_rs, dec_rt, dec_rd, dec_shamt;
   logic [5:0]  dec_funct;
   logic        dec_legal;

   assign dec_opcode = bus.instr[31:26];
   assign dec_rs     = bus.instr[25:21];
   assign dec_rt     = bus.instr[20:16];
   assign dec_rd     = bus.instr[15:11];
   assign dec_shamt  = bus.instr[10:6];
   assign dec_funct  = bus.instr[5:0];
   assign dec_legal  = (dec_opcode == 6'd0) &&
                       ((dec_funct == 6'b100000) || (dec_funct == 6'b100010) ||
                        (dec_funct == 6'b000010));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      alu_rs_d    = alu_rs_q;
      alu_rt_d    = alu_rt_q;
      alu_shamt_d = alu_shamt_q;
      alu_funct_d = alu_funct_q;
      wb_valid_d  = 1'b0;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
      illegal_d   = 1'b0;
      reg_we      = 1'b0;
      reg_waddr   = init_addr;
      reg_wdata   = init_data;

      case (state_q)
         S_IDLE: begin
            reg_we = init_we;
            if (bus.instr_valid) begin
               if (dec_legal) begin
                  // Operands come from the pre-write array even when a preload lands on this edge.
                  alu_rs_d    = regs_q[dec_rs];
                  alu_rt_d    = regs_q[dec_rt];
                  alu_shamt_d = dec_shamt;
                  alu_funct_d = dec_funct;
                  rd_d        = dec_rd;
                  cnt_d       = 4'd1;
                  state_d     = S_EXEC;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         S_EXEC: begin
            if (cnt_q >= LAT) begin
               wb_valid_d = 1'b1;
               wb_addr_d  = rd_q;
               wb_data_d  = bus.alu_rd;
               reg_we     = 1'b1;
               reg_waddr  = rd_q;
               reg_wdata  = bus.alu_rd;
               state_d    = S_WB;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_WB: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rd_q        <= '0;
         alu_rs_q    <= '0;
         alu_rt_q    <= '0;
         alu_shamt_q <= '0;
         alu_funct_q <= '0;
         wb_valid_q  <= 1'b0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         alu_rs_q    <= alu_rs_d;
         alu_rt_q    <= alu_rt_d;
         alu_shamt_q <= alu_shamt_d;
         alu_funct_q <= alu_funct_d;
         wb_valid_q  <= wb_valid_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         illegal_q   <= illegal_d;
      end
   end

   // Index 0 is never written, so it reads back as zero without a special read path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (reg_we && (reg_waddr != 5'd0)) begin
         regs_q[reg_waddr] <= reg_wdata;
      end
   end

   assign bus.instr_ready = (state_q == S_IDLE);
   assign bus.alu_rs      = alu_rs_q;
   assign bus.alu_rt      = alu_rt_q;
   assign bus.alu_shamt   = alu_shamt_q;
   assign bus.alu_funct   = alu_funct_q;
   assign bus.wb_valid    = wb_valid_q;
   assign bus.wb_addr     = wb_addr_q;
   assign bus.wb_data     = wb_data_q;
   assign bus.illegal     = illegal_q;
   assign dbg_data        = regs_q[dbg_addr];

endmodule

// File: tb/tb_rtype_issue_unit.sv
// Bench for rtype_issue_unit: one instance at ALU_LAT=1 and one at ALU_LAT=3,
// directed plan cases plus random add/sub/srl/illegal words against a register-array model.
module tb_rtype_issue_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        init_we;
   logic [4:0]  init_addr;
   logic [31:0] init_data;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_a, dbg_b;
   logic        sel;
   logic        vld;
   logic [31:0] iw_drv;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mr      [2][32];
   logic [31:0] last_rs [2];
   logic [31:0] last_rt [2];
   logic [4:0]  last_sh [2];
   logic [5:0]  last_fn [2];

   rtype_issue_unit_if ifa ();
   rtype_issue_unit_if ifb ();

   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] sh, input logic [5:0] fn);
      case (fn)
         6'b100000: return a + b;
         6'b100010: return a - b;
         6'b000010: return b >> sh;
         default:   return 32'd0;
      endcase
   endfunction

   assign ifa.instr_valid = vld & ~sel;
   assign ifb.instr_valid = vld & sel;
   assign ifa.instr       = iw_drv;
   assign ifb.instr       = iw_drv;
   assign ifa.alu_rd      = alu_model(ifa.alu_rs, ifa.alu_rt, ifa.alu_shamt, ifa.alu_funct);
   assign ifb.alu_rd      = alu_model(ifb.alu_rs, ifb.alu_rt, ifb.alu_shamt, ifb.alu_funct);

   rtype_issue_unit #(.ALU_LAT(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_a)
   );

   rtype_issue_unit #(.ALU_LAT(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_b)
   );

   wire        m_ready  = sel ? ifb.instr_ready : ifa.instr_ready;
   wire [31:0] m_rs     = sel ? ifb.alu_rs      : ifa.alu_rs;
   wire [31:0] m_rt     = sel ? ifb.alu_rt      : ifa.alu_rt;
   wire [4:0]  m_sh     = sel ? ifb.alu_shamt   : ifa.alu_shamt;
   wire [5:0]  m_fn     = sel ? ifb.alu_funct   : ifa.alu_funct;
   wire        m_wbv    = sel ? ifb.wb_valid    : ifa.wb_valid;
   wire [4:0]  m_wba    = sel ? ifb.wb_addr     : ifa.wb_addr;
   wire [31:0] m_wbd    = sel ? ifb.wb_data     : ifa.wb_data;
   wire        m_ill    = sel ? ifb.illegal     : ifa.illegal;
   wire [31:0] m_dbg    = sel ? dbg_b           : dbg_a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 32; i++) mr[d][i] = 32'd0;
         last_rs[d] = '0; last_rt[d] = '0; last_sh[d] = '0; last_fn[d] = '0;
      end
   endtask

   task automatic check_outputs_reset(input string tag);
      chk({tag, "_ready"}, 32'(m_ready), 32'd1);
      chk({tag, "_wbv"},   32'(m_wbv),   32'd0);
      chk({tag, "_ill"},   32'(m_ill),   32'd0);
      chk({tag, "_rs"},    m_rs,         32'd0);
      chk({tag, "_rt"},    m_rt,         32'd0);
      chk({tag, "_sh"},    32'(m_sh),    32'd0);
      chk({tag, "_fn"},    32'(m_fn),    32'd0);
      chk({tag, "_wba"},   32'(m_wba),   32'd0);
      chk({tag, "_wbd"},   m_wbd,        32'd0);
   endtask

   task automatic check_regs(input string tag);
      int d = sel ? 1 : 0;
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #1;
         chk(tag, m_dbg, mr[d][i]);
      end
   endtask

   // Preloads reach both instances; called only while both are idle.
   task automatic preload(input logic [4:0] a, input logic [31:0] v);
      init_we = 1'b1; init_addr = a; init_data = v;
      @(negedge clk);
      init_we = 1'b0;
      if (a != 5'd0) begin mr[0][a] = v; mr[1][a] = v; end
   endtask

   task automatic expect_dbg(input string tag, input logic [4:0] a, input logic [31:0] v);
      dbg_addr = a;
      #1;
      chk(tag, m_dbg, v);
   endtask

   // mode 0: plain issue; 1: preload on the accepting edge; 2: preload attempt during EXEC.
   task automatic issue(input logic [31:0] iw, input int mode);
      int          d   = sel ? 1 : 0;
      int          lat = sel ? 3 : 1;
      logic [4:0]  rs  = iw[25:21];
      logic [4:0]  rt  = iw[20:16];
      logic [4:0]  rd  = iw[15:11];
      logic [4:0]  sh  = iw[10:6];
      logic [5:0]  fn  = iw[5:0];
      bit          legal;
      logic [31:0] a, b, res;
      logic [4:0]  pa;
      logic [31:0] pd;
      int          lowcnt;

      legal = (iw[31:26] == 6'd0) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h02);
      a = mr[d][rs];
      b = mr[d][rt];
      if (fn == 6'h20)      res = a + b;
      else if (fn == 6'h22) res = a - b;
      else                  res = b >> sh;
      pa = 5'($urandom_range(0, 31));
      pd = $urandom;

      iw_drv = iw; vld = 1'b1;
      if (mode == 1) begin init_we = 1'b1; init_addr = pa; init_data = pd; end
      chk("ready_before_issue", 32'(m_ready), 32'd1);
      @(negedge clk);
      vld = 1'b0; init_we = 1'b0;
      if (mode == 1 && pa != 5'd0) begin mr[0][pa] = pd; mr[1][pa] = pd; end

      if (!legal) begin
         chk("illegal_pulse",  32'(m_ill),   32'd1);
         chk("illegal_ready",  32'(m_ready), 32'd1);
         chk("illegal_no_wb",  32'(m_wbv),   32'd0);
         chk("illegal_rs_hold", m_rs,        last_rs[d]);
         chk("illegal_fn_hold", 32'(m_fn),   32'(last_fn[d]));
         @(negedge clk);
         chk("illegal_one_cycle", 32'(m_ill), 32'd0);
         chk("illegal_no_wb2",    32'(m_wbv), 32'd0);
         return;
      end

      chk("exec_ill",   32'(m_ill), 32'd0);
      chk("alu_rs",     m_rs,       a);
      chk("alu_rt",     m_rt,       b);
      chk("alu_shamt",  32'(m_sh),  32'(sh));
      chk("alu_funct",  32'(m_fn),  32'(fn));
      chk("exec_no_wb", 32'(m_wbv), 32'd0);
      chk("exec_ready", 32'(m_ready), 32'd0);
      last_rs[d] = a; last_rt[d] = b; last_sh[d] = sh; last_fn[d] = fn;
      lowcnt = m_ready ? 0 : 1;

      if (mode == 2) begin
         init_we = 1'b1; init_addr = pa; init_data = pd;
         if (pa != 5'd0) mr[1-d][pa] = pd;
      end

      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         init_we = 1'b0;
         if (k < lat) begin
            chk("wait_no_wb",  32'(m_wbv),   32'd0);
            chk("wait_ready",  32'(m_ready), 32'd0);
            chk("wait_rs_hold", m_rs,        a);
         end else if (k == lat) begin
            chk("wb_valid", 32'(m_wbv),   32'd1);
            chk("wb_addr",  32'(m_wba),   32'(rd));
            chk("wb_data",  m_wbd,        res);
            chk("wb_ready", 32'(m_ready), 32'd0);
            if (rd != 5'd0) mr[d][rd] = res;
         end else begin
            chk("wb_pulse_end", 32'(m_wbv),   32'd0);
            chk("ready_again",  32'(m_ready), 32'd1);
         end
         if (!m_ready) lowcnt++;
      end
      chk("ready_low_cycles", 32'(lowcnt), 32'(lat + 1));
      expect_dbg("dbg_rd", rd, mr[d][rd]);
   endtask

   function automatic logic [31:0] gen_iw();
      logic [5:0]  fn;
      logic [31:0] w;
      case ($urandom_range(0, 2))
         0:       fn = 6'h20;
         1:       fn = 6'h22;
         default: fn = 6'h02;
      endcase
      w = {6'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), fn};
      if ($urandom_range(0, 7) == 0) w = $urandom;
      return w;
   endfunction

   initial begin
      rst_n = 1'b0; sel = 1'b0; vld = 1'b0; iw_drv = '0;
      init_we = 1'b0; init_addr = '0; init_data = '0; dbg_addr = '0;
      clear_model();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check_outputs_reset("rst_a");
      check_regs("rst_regs_a");
      sel = 1'b1;
      check_outputs_reset("rst_b");
      sel = 1'b0;

      // add r3, r1, r2
      preload(5'd1, 32'd0); preload(5'd2, 32'd1);
      issue(32'h00221820, 0);
      expect_dbg("add_r3", 5'd3, 32'd1);

      // sub r6, r4, r5 then swapped operands
      preload(5'd4, 32'd7); preload(5'd5, 32'd3);
      issue(32'h00853022, 0);
      expect_dbg("sub_r6", 5'd6, 32'd4);
      issue(32'h00A43022, 0);
      expect_dbg("sub_swap_r6", 5'd6, 32'hFFFFFFFC);

      // srl r8, r7, 2 then srl r8, r7, 1 with R7 = 13
      preload(5'd7, 32'd8);
      issue(32'h00074082, 0);
      expect_dbg("srl_r8", 5'd8, 32'd2);
      preload(5'd7, 32'd13);
      issue(32'h00074042, 0);
      expect_dbg("srl2_r8", 5'd8, 32'd6);

      // destination r0 and preload to r0
      issue(32'h00220020, 0);
      expect_dbg("r0_after_wb", 5'd0, 32'd0);
      preload(5'd0, 32'hDEADBEEF);
      expect_dbg("r0_after_preload", 5'd0, 32'd0);

      // illegal words: lw, and R-type funct 100100
      issue(32'h8C220000, 0);
      issue(32'h00221824, 0);
      check_regs("illegal_regs");

      // preload coinciding with accept, and preload attempt during EXEC
      issue(32'h00221820, 1);
      issue(32'h00853022, 2);
      check_regs("mixed_regs_a");

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0) preload(5'($urandom_range(0, 31)), $urandom);
         issue(gen_iw(), int'($urandom_range(0, 2)));
      end
      check_regs("rand_regs_a");

      sel = 1'b1;
      issue(32'h00221820, 0);
      for (int n = 0; n < 12; n++) issue(gen_iw(), int'($urandom_range(0, 2)));
      check_regs("rand_regs_b");

      // reset while the LAT=3 instance is in EXEC
      preload(5'd9, 32'h12345678);
      iw_drv = 32'h01295020; vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      chk("pre_reset_exec", 32'(m_ready), 32'd0);
      rst_n = 1'b0;
      clear_model();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("reset_no_wb", 32'(m_wbv), 32'd0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("post_reset_no_wb", 32'(m_wbv), 32'd0);
      end
      check_outputs_reset("post_reset_b");
      check_regs("post_reset_regs_b");
      sel = 1'b0;
      check_regs("post_reset_regs_a");
      issue(32'h00221820, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
